// File: rtl/ventilation_driver.sv
// Ventilation fan PWM driver: soft-start/soft-stop duty ramps with minimum on/off dwell
// so the fan power stage is never short-cycled.
module ventilation_driver #(
  parameter int unsigned PWM_PERIOD = 16,
  parameter int unsigned MIN_ON     = 30,
  parameter int unsigned MIN_OFF    = 30
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_fan_request,
  input  logic [1:0] i_speed_level,
  output logic       o_fan_pwm,
  output logic       o_fan_on,
  output logic       o_at_speed,
  output logic [2:0] o_fan_state
);

  localparam int unsigned DW        = $clog2(PWM_PERIOD + 1);
  localparam int unsigned CW        = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned DWELL_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned TW        = $clog2(DWELL_MAX + 1);

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StRampUp   = 3'd1,
    StRun      = 3'd2,
    StRampDown = 3'd3,
    StHoldOff  = 3'd4
  } state_e;

  state_e          r_state;
  logic [DW-1:0]   r_duty;
  logic [CW-1:0]   r_pwm_cnt;
  logic [TW-1:0]   r_dwell;
  logic            r_pwm;
  logic            r_fan_on;
  logic            r_at_speed;

  state_e          w_state_d;
  logic [DW-1:0]   w_duty_d;
  logic [TW-1:0]   w_dwell_d;
  logic [DW-1:0]   w_target;
  logic            w_boundary;
  logic            w_dwell_clr;
  logic            w_min_on_met;

  assign w_target     = DW'((32'(i_speed_level) + 32'd1) * PWM_PERIOD / 32'd4);
  assign w_boundary   = (r_pwm_cnt == CW'(PWM_PERIOD - 1));
  assign w_min_on_met = (32'(r_dwell) >= MIN_ON);

  always_comb begin
    w_state_d   = r_state;
    w_dwell_clr = 1'b0;
    unique case (r_state)
      StOff: begin
        if (i_fan_request) begin
          w_state_d   = StRampUp;
          w_dwell_clr = 1'b1;
        end
      end
      StRampUp: begin
        // Stop beats target-reached, but only once the minimum on-time has elapsed.
        if (!i_fan_request && w_min_on_met) begin
          w_state_d = StRampDown;
        end else if (r_duty == w_target) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (!i_fan_request && w_min_on_met) begin
          w_state_d = StRampDown;
        end
      end
      StRampDown: begin
        if (i_fan_request) begin
          w_state_d = StRampUp;
        end else if (r_duty == '0) begin
          w_state_d   = StHoldOff;
          w_dwell_clr = 1'b1;
        end
      end
      StHoldOff: begin
        if (32'(r_dwell) == MIN_OFF - 1) begin
          w_state_d = StOff;
        end
      end
      default: w_state_d = StOff;
    endcase
  end

  // Duty steps follow the state being left, so a boundary coinciding with a
  // transition still uses the old direction and target.
  always_comb begin
    w_duty_d = r_duty;
    if (w_boundary) begin
      unique case (r_state)
        StRampUp, StRun: begin
          if (r_duty < w_target) begin
            w_duty_d = r_duty + DW'(1);
          end else if (r_duty > w_target) begin
            w_duty_d = r_duty - DW'(1);
          end
        end
        StRampDown: begin
          if (r_duty != '0) begin
            w_duty_d = r_duty - DW'(1);
          end
        end
        default: w_duty_d = '0;
      endcase
    end
  end

  always_comb begin
    if (w_dwell_clr) begin
      w_dwell_d = '0;
    end else if (r_dwell == TW'(DWELL_MAX)) begin
      w_dwell_d = r_dwell;
    end else begin
      w_dwell_d = r_dwell + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= StOff;
      r_duty     <= '0;
      r_pwm_cnt  <= '0;
      r_dwell    <= '0;
      r_pwm      <= 1'b0;
      r_fan_on   <= 1'b0;
      r_at_speed <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_duty     <= w_duty_d;
      r_pwm_cnt  <= w_boundary ? '0 : r_pwm_cnt + CW'(1);
      r_dwell    <= w_dwell_d;
      r_pwm      <= (DW'(r_pwm_cnt) < r_duty);
      r_fan_on   <= (w_state_d == StRampUp) || (w_state_d == StRun) ||
                    (w_state_d == StRampDown);
      r_at_speed <= (w_state_d == StRun) && (w_duty_d == w_target);
    end
  end

  assign o_fan_pwm   = r_pwm;
  assign o_fan_on    = r_fan_on;
  assign o_at_speed  = r_at_speed;
  assign o_fan_state = r_state;

endmodule
